// File: rtl/decouple_fifo.sv
// decouple_fifo: valid/ready decoupling FIFO with arbitrary depth, a fill-level
// output, almost-full/almost-empty flags, synchronous flush and an optional
// ready pass-through that lets a full FIFO accept a word in the cycle it drains.
// Pointers wrap explicitly at DEPTH-1. Occupancy is held in a separate count
// register so full and empty never need pointer comparison.
module decouple_fifo #(
   parameter int DIN        = 16,
   parameter int DEPTH      = 2,
   parameter int AFULL      = DEPTH - 1,
   parameter int AEMPTY     = 1,
   parameter bit PASS_READY = 1'b0,
   localparam int CW        = $clog2(DEPTH + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           flush,
   input  logic           din_valid,
   input  logic [DIN-1:0] din_data,
   output logic           din_ready,
   output logic           dout_valid,
   output logic [DIN-1:0] dout_data,
   input  logic           dout_ready,
   output logic [CW-1:0]  count,
   output logic           almost_full,
   output logic           almost_empty
);

   localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [DIN-1:0] mem_q [DEPTH];
   logic [PW-1:0]  wp_q, wp_d;
   logic [PW-1:0]  rp_q, rp_d;
   logic [CW-1:0]  count_q, count_d;
   logic           full, empty;
   logic           wr, rd;

   assign full  = (count_q == CNT_FULL);
   assign empty = (count_q == '0);

   // Ready is held low during reset and flush; pass-through mode adds the
   // combinational dout_ready path so a full FIFO can refill its freed slot.
   assign din_ready  = rst & ~flush & (~full | (PASS_READY & dout_ready));
   assign dout_valid = ~empty & ~flush;
   assign dout_data  = mem_q[rp_q];

   assign wr = din_valid & din_ready & ~flush;
   assign rd = dout_valid & dout_ready & ~flush;

   assign count        = count_q;
   assign almost_full  = (int'(count_q) >= AFULL);
   assign almost_empty = (int'(count_q) <= AEMPTY);

   // Next pointer and occupancy; flush overrides any handshake.
   always_comb begin
      wp_d    = wp_q;
      rp_d    = rp_q;
      count_d = count_q;
      if (flush) begin
         wp_d    = '0;
         rp_d    = '0;
         count_d = '0;
      end else begin
         if (wr) wp_d = (wp_q == PTR_LAST) ? '0 : wp_q + PTR_ONE;
         if (rd) rp_d = (rp_q == PTR_LAST) ? '0 : rp_q + PTR_ONE;
         case ({wr, rd})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // Control state register; reset clears occupancy without a clock edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
      end
   end

   // Storage array; written only on an accepted word, never reset.
   always_ff @(posedge clk) begin
      if (wr) mem_q[wp_q] <= din_data;
   end

endmodule

// File: tb/tb_decouple_fifo.sv
// Bench for decouple_fifo: two DEPTH=5, DIN=8 instances (ready modes 0 and 1),
// a queue model per instance checked every cycle, and directed scenarios
// with literal expectations.
module tb_decouple_fifo;

   localparam int D = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       flush_s      [2];
   logic       din_valid_s  [2];
   logic [7:0] din_data_s   [2];
   logic       din_ready_s  [2];
   logic       dout_valid_s [2];
   logic [7:0] dout_data_s  [2];
   logic       dout_ready_s [2];
   logic [2:0] count_s      [2];
   logic       af_s         [2];
   logic       ae_s         [2];

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   decouple_fifo #(.DIN(8), .DEPTH(D), .PASS_READY(1'b0)) u0 (
      .clk(clk), .rst(rst), .flush(flush_s[0]),
      .din_valid(din_valid_s[0]), .din_data(din_data_s[0]), .din_ready(din_ready_s[0]),
      .dout_valid(dout_valid_s[0]), .dout_data(dout_data_s[0]), .dout_ready(dout_ready_s[0]),
      .count(count_s[0]), .almost_full(af_s[0]), .almost_empty(ae_s[0]));

   decouple_fifo #(.DIN(8), .DEPTH(D), .PASS_READY(1'b1)) u1 (
      .clk(clk), .rst(rst), .flush(flush_s[1]),
      .din_valid(din_valid_s[1]), .din_data(din_data_s[1]), .din_ready(din_ready_s[1]),
      .dout_valid(dout_valid_s[1]), .dout_data(dout_data_s[1]), .dout_ready(dout_ready_s[1]),
      .count(count_s[1]), .almost_full(af_s[1]), .almost_empty(ae_s[1]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Queue model per instance plus a per-cycle compare on the falling edge.
   for (genvar gi = 0; gi < 2; gi++) begin : g_model
      localparam bit PR = (gi == 1);
      bit [7:0] q[$];
      bit       w, r;
      int       ec;
      bit       edv, edr;

      always @(posedge clk or negedge rst) begin
         if (!rst) q.delete();
         else if (flush_s[gi]) q.delete();
         else begin
            r = (q.size() > 0) && dout_ready_s[gi];
            w = din_valid_s[gi] && ((q.size() < D) || (PR && dout_ready_s[gi]));
            if (r) void'(q.pop_front());
            if (w) q.push_back(din_data_s[gi]);
         end
      end

      always @(negedge clk) begin
         ec  = q.size();
         edv = rst && !flush_s[gi] && (ec > 0);
         edr = rst && !flush_s[gi] && ((ec < D) || (PR && dout_ready_s[gi]));
         chk($sformatf("u%0d.count", gi), 32'(count_s[gi]), 32'(ec));
         chk($sformatf("u%0d.dout_valid", gi), 32'(dout_valid_s[gi]), 32'(edv));
         chk($sformatf("u%0d.din_ready", gi), 32'(din_ready_s[gi]), 32'(edr));
         chk($sformatf("u%0d.almost_full", gi), 32'(af_s[gi]), 32'(ec >= D - 1));
         chk($sformatf("u%0d.almost_empty", gi), 32'(ae_s[gi]), 32'(ec <= 1));
         if (edv) chk($sformatf("u%0d.dout_data", gi), 32'(dout_data_s[gi]), 32'(q[0]));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input int i, input logic [7:0] base, input int n);
      dout_ready_s[i] = 1'b0;
      for (int k = 0; k < n; k++) begin
         din_valid_s[i] = 1'b1;
         din_data_s[i]  = 8'(base + k);
         cyc();
      end
      din_valid_s[i] = 1'b0;
   endtask

   task automatic drain(input int i);
      dout_ready_s[i] = 1'b1;
      for (int k = 0; k < 8; k++) cyc();
      dout_ready_s[i] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [7:0] word;
   logic       acc, tk;
   int         idx, nrx;

   initial begin
      for (int i = 0; i < 2; i++) begin
         flush_s[i] = 1'b0; din_valid_s[i] = 1'b0; din_data_s[i] = '0; dout_ready_s[i] = 1'b0;
      end
      cyc(); cyc();
      chk("rst.count", 32'(count_s[0]), 0);
      chk("rst.din_ready", 32'(din_ready_s[0]), 0);
      chk("rst.almost_empty", 32'(ae_s[0]), 1);
      chk("rst.almost_full", 32'(af_s[0]), 0);
      rst = 1'b1;
      cyc();

      // Fill and drain
      for (int k = 0; k < 5; k++) begin
         din_valid_s[0] = 1'b1;
         din_data_s[0]  = 8'(8'h10 + k);
         cyc();
         chk("fill.count", 32'(count_s[0]), 32'(k + 1));
         chk("fill.almost_full", 32'(af_s[0]), 32'(k + 1 >= 4));
      end
      din_valid_s[0] = 1'b0;
      chk("fill.din_ready_full", 32'(din_ready_s[0]), 0);
      dout_ready_s[0] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         chk("drain.dout_data", 32'(dout_data_s[0]), 32'(8'h10 + k));
         chk("drain.dout_valid", 32'(dout_valid_s[0]), 1);
         cyc();
         chk("drain.count", 32'(count_s[0]), 32'(4 - k));
         chk("drain.almost_empty", 32'(ae_s[0]), 32'(4 - k <= 1));
      end
      chk("drain.empty", 32'(dout_valid_s[0]), 0);
      dout_ready_s[0] = 1'b0;

      // Wrap-around with random stalls
      idx = 0; nrx = 0;
      for (int c = 0; c < 400 && nrx < 13; c++) begin
         if (!din_valid_s[0] && idx < 13 && $urandom_range(0, 3) != 0) begin
            din_valid_s[0] = 1'b1;
            din_data_s[0]  = 8'(8'h30 + idx);
         end
         dout_ready_s[0] = ($urandom_range(0, 2) != 0);
         #1;
         acc = din_valid_s[0] && din_ready_s[0];
         tk  = dout_valid_s[0] && dout_ready_s[0];
         if (tk) begin
            chk("wrap.dout_data", 32'(dout_data_s[0]), 32'(8'h30 + nrx));
            nrx++;
         end
         cyc();
         if (acc) begin
            idx++;
            din_valid_s[0] = 1'b0;
         end
      end
      chk("wrap.received", 32'(nrx), 13);
      din_valid_s[0] = 1'b0; dout_ready_s[0] = 1'b0;
      cyc();

      // Simultaneous read/write at full, pass-through mode
      fill(1, 8'hA0, 5);
      chk("pr1.full_count", 32'(count_s[1]), 5);
      din_valid_s[1] = 1'b1; din_data_s[1] = 8'hB0; dout_ready_s[1] = 1'b1;
      #1;
      chk("pr1.din_ready", 32'(din_ready_s[1]), 1);
      chk("pr1.head", 32'(dout_data_s[1]), 32'h A0);
      cyc();
      din_valid_s[1] = 1'b0;
      chk("pr1.count_stays", 32'(count_s[1]), 5);
      for (int k = 0; k < 5; k++) begin
         word = (k < 4) ? 8'(8'hA1 + k) : 8'hB0;
         chk("pr1.order", 32'(dout_data_s[1]), 32'(word));
         cyc();
      end
      chk("pr1.empty", 32'(dout_valid_s[1]), 0);
      dout_ready_s[1] = 1'b0;

      // Same stimulus without pass-through
      fill(0, 8'hA0, 5);
      din_valid_s[0] = 1'b1; din_data_s[0] = 8'hB0; dout_ready_s[0] = 1'b1;
      #1;
      chk("pr0.din_ready", 32'(din_ready_s[0]), 0);
      cyc();
      chk("pr0.count", 32'(count_s[0]), 4);
      chk("pr0.head", 32'(dout_data_s[0]), 32'h A1);
      cyc();
      din_valid_s[0] = 1'b0;
      chk("pr0.count2", 32'(count_s[0]), 4);
      for (int k = 0; k < 4; k++) begin
         word = (k < 3) ? 8'(8'hA2 + k) : 8'hB0;
         chk("pr0.order", 32'(dout_data_s[0]), 32'(word));
         cyc();
      end
      chk("pr0.empty", 32'(dout_valid_s[0]), 0);
      dout_ready_s[0] = 1'b0;

      // Flush
      fill(0, 8'h01, 3);
      chk("flush.pre_count", 32'(count_s[0]), 3);
      flush_s[0] = 1'b1; din_valid_s[0] = 1'b1; din_data_s[0] = 8'h99; dout_ready_s[0] = 1'b1;
      #1;
      chk("flush.din_ready", 32'(din_ready_s[0]), 0);
      chk("flush.dout_valid", 32'(dout_valid_s[0]), 0);
      cyc();
      flush_s[0] = 1'b0; din_valid_s[0] = 1'b0; dout_ready_s[0] = 1'b0;
      chk("flush.count", 32'(count_s[0]), 0);
      chk("flush.dout_valid_after", 32'(dout_valid_s[0]), 0);
      din_valid_s[0] = 1'b1; din_data_s[0] = 8'h55;
      cyc();
      din_valid_s[0] = 1'b0;
      chk("flush.next_valid", 32'(dout_valid_s[0]), 1);
      chk("flush.next_data", 32'(dout_data_s[0]), 32'h55);
      chk("flush.next_count", 32'(count_s[0]), 1);
      drain(0);

      // Asynchronous reset mid-operation
      fill(0, 8'h61, 2);
      chk("arst.pre_count", 32'(count_s[0]), 2);
      #2;
      rst = 1'b0;
      #1;
      chk("arst.count", 32'(count_s[0]), 0);
      chk("arst.dout_valid", 32'(dout_valid_s[0]), 0);
      chk("arst.din_ready", 32'(din_ready_s[0]), 0);
      cyc();
      rst = 1'b1;
      din_valid_s[0] = 1'b1; din_data_s[0] = 8'h77;
      cyc();
      din_valid_s[0] = 1'b0;
      chk("arst.data", 32'(dout_data_s[0]), 32'h77);
      chk("arst.count_after", 32'(count_s[0]), 1);
      drain(0);

      // Hold stability while producer keeps writing
      fill(0, 8'hC0, 1);
      word = 8'hC1;
      for (int k = 0; k < 10; k++) begin
         din_valid_s[0] = 1'b1;
         din_data_s[0]  = word;
         #1;
         acc = din_ready_s[0];
         chk("hold.data", 32'(dout_data_s[0]), 32'h C0);
         cyc();
         if (acc) word = 8'(word + 1);
         chk("hold.count", 32'(count_s[0]), 32'((k + 2 < 5) ? k + 2 : 5));
      end
      din_valid_s[0] = 1'b0;
      dout_ready_s[0] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         chk("hold.drain", 32'(dout_data_s[0]), 32'(8'hC0 + k));
         cyc();
      end
      dout_ready_s[0] = 1'b0;
      cyc();
      chk("end.count0", 32'(count_s[0]), 0);
      chk("end.count1", 32'(count_s[1]), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
